// File: rtl/coreboard1588_scan_seq.sv
// Channel scan sequencer for the ADS868x front end: periodically walks the external 8:1
// mux and the ADC's internal 4:1 mux, requesting one conversion per channel.
module coreboard1588_scan_seq #(
  parameter int unsigned NUM_CH        = 32,
  parameter int unsigned SETTLE_CYCLES = 100,
  parameter int unsigned CONV_TIMEOUT  = 4096
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        ctrl_scan_enable,
  input  logic [31:0] ctrl_scan_period,
  input  logic        ctrl_err_clr,
  output logic        conv_req,
  input  logic        conv_done,
  output logic [7:0]  ch_id,
  output logic [2:0]  ext_mux_sel,
  output logic [1:0]  adc_int_ch,
  output logic        scan_active,
  output logic        scan_done,
  output logic        overrun,
  output logic        timeout_err
);

  localparam logic [4:0]  ChLast     = 5'(NUM_CH - 1);
  localparam logic [15:0] SettleLoad = 16'(SETTLE_CYCLES);
  localparam logic [15:0] TmoLast    = 16'(CONV_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StConv} state_e;

  state_e      state_q;
  logic [31:0] period_cnt_q, period_cnt_d;
  logic [4:0]  ch_q;
  logic [15:0] settle_q, tmo_q;
  logic        conv_req_q, scan_active_q, scan_done_q, overrun_q, timeout_err_q;
  logic        period_run, tick, tmo_hit, conv_end, ovr_set, tmo_set;

  assign period_run = ctrl_scan_enable && (ctrl_scan_period != 32'd0);
  assign tick       = period_run && (period_cnt_q == ctrl_scan_period - 32'd1);

  // Period is compared live; >= also recovers if the period shrinks below the count.
  always_comb begin
    period_cnt_d = period_cnt_q + 32'd1;
    if (!period_run || (period_cnt_q >= ctrl_scan_period - 32'd1)) begin
      period_cnt_d = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      period_cnt_q <= '0;
    end else begin
      period_cnt_q <= period_cnt_d;
    end
  end

  assign tmo_hit  = (state_q == StConv) && !conv_done && (tmo_q == TmoLast);
  assign conv_end = (state_q == StConv) && (conv_done || tmo_hit);
  assign ovr_set  = tick && scan_active_q;
  assign tmo_set  = tmo_hit && ctrl_scan_enable;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      ch_q          <= '0;
      settle_q      <= '0;
      tmo_q         <= '0;
      conv_req_q    <= 1'b0;
      scan_active_q <= 1'b0;
      scan_done_q   <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;

      // Set beats clear when both land in the same cycle.
      if (ovr_set) begin
        overrun_q <= 1'b1;
      end else if (ctrl_err_clr) begin
        overrun_q <= 1'b0;
      end
      if (tmo_set) begin
        timeout_err_q <= 1'b1;
      end else if (ctrl_err_clr) begin
        timeout_err_q <= 1'b0;
      end

      if (!ctrl_scan_enable) begin
        state_q       <= StIdle;
        ch_q          <= '0;
        conv_req_q    <= 1'b0;
        scan_active_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (tick) begin
              state_q       <= StSettle;
              ch_q          <= '0;
              settle_q      <= SettleLoad;
              scan_active_q <= 1'b1;
            end
          end
          StSettle: begin
            if (settle_q <= 16'd1) begin
              state_q    <= StConv;
              conv_req_q <= 1'b1;
              tmo_q      <= '0;
            end else begin
              settle_q <= settle_q - 16'd1;
            end
          end
          StConv: begin
            if (conv_end) begin
              conv_req_q <= 1'b0;
              if (ch_q == ChLast) begin
                state_q       <= StIdle;
                ch_q          <= '0;
                scan_active_q <= 1'b0;
                scan_done_q   <= 1'b1;
              end else begin
                state_q  <= StSettle;
                ch_q     <= ch_q + 5'd1;
                settle_q <= SettleLoad;
              end
            end else begin
              tmo_q <= tmo_q + 16'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign conv_req    = conv_req_q;
  assign ch_id       = {3'b000, ch_q};
  assign ext_mux_sel = ch_q[4:2];
  assign adc_int_ch  = ch_q[1:0];
  assign scan_active = scan_active_q;
  assign scan_done   = scan_done_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_coreboard1588_scan_seq.sv
// Scoreboard bench for coreboard1588_scan_seq: expected channel order and scan_done events
// are queued with the stimulus and retired by a negedge monitor.
`timescale 1ns/1ps
module tb_coreboard1588_scan_seq;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        en = 1'b0;
  logic [31:0] period = '0;
  logic        err_clr = 1'b0;
  logic        drv_done = 1'b0;
  logic        spur_done = 1'b0;
  logic        conv_done;
  logic        conv_req, scan_active, scan_done, overrun, timeout_err;
  logic [7:0]  ch_id;
  logic [2:0]  ext_mux_sel;
  logic [1:0]  adc_int_ch;

  always #5 aclk = ~aclk;
  assign conv_done = drv_done | spur_done;

  coreboard1588_scan_seq #(
    .NUM_CH       (32),
    .SETTLE_CYCLES(4),
    .CONV_TIMEOUT (16)
  ) u_dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .ctrl_scan_enable(en),
    .ctrl_scan_period(period),
    .ctrl_err_clr    (err_clr),
    .conv_req        (conv_req),
    .conv_done       (conv_done),
    .ch_id           (ch_id),
    .ext_mux_sel     (ext_mux_sel),
    .adc_int_ch      (adc_int_ch),
    .scan_active     (scan_active),
    .scan_done       (scan_done),
    .overrun         (overrun),
    .timeout_err     (timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: answers conv_done 3 cycles after conv_req, optionally silent on channel 5.
  bit withhold = 1'b0;
  int req_age = 0;
  always @(negedge aclk) begin
    if (conv_req) begin
      req_age++;
      drv_done = (req_age == 3) && !(withhold && ch_id[4:0] == 5'd5);
    end else begin
      req_age  = 0;
      drv_done = 1'b0;
    end
  end

  // Monitor / scoreboard
  logic [4:0] exp_ch[$];
  int         exp_done[$];
  logic       req_prev = 1'b0;
  logic [4:0] cur_ch = '0;
  int         req_len = 0;
  int         len5 = 0;
  int         req_count = 0;
  int         done_count = 0;

  always @(negedge aclk) begin
    logic [4:0] e;
    if (conv_req && !req_prev) begin
      check("req_expected", 32'(exp_ch.size() != 0), 1);
      if (exp_ch.size() != 0) begin
        e = exp_ch.pop_front();
        check("ch_id", ch_id, {27'd0, e});
        check("ext_mux_sel", ext_mux_sel, {29'd0, e[4:2]});
        check("adc_int_ch", adc_int_ch, {30'd0, e[1:0]});
      end
      cur_ch  = ch_id[4:0];
      req_len = 0;
      req_count++;
    end
    if (conv_req) req_len++;
    if (!conv_req && req_prev && cur_ch == 5'd5) len5 = req_len;
    if (scan_done) begin
      check("done_expected", 32'(exp_done.size() != 0), 1);
      if (exp_done.size() != 0) void'(exp_done.pop_front());
      done_count++;
    end
    req_prev = conv_req;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic push_scan(input int last, input bit with_done);
    for (int c = 0; c <= last; c++) exp_ch.push_back(5'(c));
    if (with_done) exp_done.push_back(1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_count < target && n < budget) begin
      cycles(1);
      n++;
    end
    check("scan_done_seen", done_count, target);
  endtask

  task automatic wait_active(input string tag, input int budget, output int n);
    n = 0;
    while (!scan_active && n < budget) begin
      cycles(1);
      n++;
    end
    check(tag, scan_active, 1);
  endtask

  initial begin
    int n;
    int t0;

    cycles(3);
    check("rst_conv_req", conv_req, 0);
    check("rst_ch_id", ch_id, 0);
    check("rst_scan_active", scan_active, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout_err, 0);
    aresetn = 1'b1;
    cycles(2);

    // Full scan, no faults
    push_scan(31, 1);
    period = 1000;
    en = 1'b1;
    wait_done(1, 3000);
    check("t1_queue_empty", exp_ch.size(), 0);
    check("t1_req_count", req_count, 32);
    check("t1_req_len", len5, 3);
    check("t1_overrun", overrun, 0);
    check("t1_timeout", timeout_err, 0);
    check("t1_active_low", scan_active, 0);
    en = 1'b0;
    cycles(2);

    // Period shorter than the scan: overrun one period after start
    push_scan(31, 1);
    period = 100;
    en = 1'b1;
    wait_active("t2_started", 500, n);
    n = 0;
    while (!overrun && n < 500) begin
      cycles(1);
      n++;
    end
    check("t2_overrun_delay", n, 100);
    check("t2_active_at_overrun", scan_active, 1);
    wait_done(2, 1000);
    en = 1'b0;
    check("t2_queue_empty", exp_ch.size(), 0);
    check("t2_overrun_sticky", overrun, 1);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    check("t2_overrun_clr", overrun, 0);
    check("t2_timeout", timeout_err, 0);
    cycles(2);

    // Withheld conv_done on channel 5
    withhold = 1'b1;
    len5 = 0;
    push_scan(31, 1);
    period = 1000;
    en = 1'b1;
    wait_done(3, 3000);
    check("t3_req_len", len5, 16);
    check("t3_timeout_err", timeout_err, 1);
    check("t3_queue_empty", exp_ch.size(), 0);
    en = 1'b0;
    withhold = 1'b0;
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    check("t3_timeout_clr", timeout_err, 0);
    cycles(2);

    // Enable dropped while converting channel 10
    push_scan(10, 0);
    en = 1'b1;
    n = 0;
    while (!(conv_req && ch_id == 8'd10) && n < 3000) begin
      cycles(1);
      n++;
    end
    check("t4_reached_ch10", ch_id, 10);
    en = 1'b0;
    cycles(1);
    check("t4_conv_req", conv_req, 0);
    check("t4_ch_id", ch_id, 0);
    check("t4_active", scan_active, 0);
    cycles(20);
    check("t4_no_done", done_count, 3);
    check("t4_queue_empty", exp_ch.size(), 0);
    push_scan(31, 1);
    en = 1'b1;
    wait_done(4, 3000);
    check("t4_rescan_queue", exp_ch.size(), 0);
    en = 1'b0;
    cycles(2);

    // Asynchronous reset during settle of channel 2
    push_scan(1, 0);
    en = 1'b1;
    n = 0;
    while (!(scan_active && !conv_req && ch_id == 8'd2) && n < 3000) begin
      cycles(1);
      n++;
    end
    check("t5_in_settle_ch2", ch_id, 2);
    #2;
    aresetn = 1'b0;
    #1;
    check("t5_async_active", scan_active, 0);
    check("t5_async_ch_id", ch_id, 0);
    check("t5_async_conv_req", conv_req, 0);
    cycles(2);
    check("t5_no_done", scan_done, 0);
    check("t5_queue_empty", exp_ch.size(), 0);
    push_scan(31, 1);
    aresetn = 1'b1;
    wait_active("t5_restarted", 3000, n);
    check("t5_first_tick", n, 1000);
    wait_done(5, 3000);
    en = 1'b0;
    cycles(2);

    // Spurious conv_done in idle and in settle
    spur_done = 1'b1;
    cycles(1);
    spur_done = 1'b0;
    cycles(1);
    check("t6_idle_active", scan_active, 0);
    check("t6_idle_req", conv_req, 0);
    push_scan(31, 1);
    en = 1'b1;
    wait_active("t6_started", 3000, n);
    spur_done = 1'b1;
    n = 0;
    while (!conv_req && n < 50) begin
      cycles(1);
      spur_done = 1'b0;
      n++;
    end
    check("t6_settle_len", n, 4);
    wait_done(6, 3000);
    check("t6_queue_empty", exp_ch.size(), 0);
    en = 1'b0;
    cycles(2);

    // Zero period never starts a scan
    period = 0;
    en = 1'b1;
    t0 = req_count;
    cycles(10000);
    check("t6_zero_period_reqs", req_count - t0, 0);
    check("t6_zero_period_active", scan_active, 0);
    en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
